// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: PC-side request, instruction-memory port and
// decode-side handshake. The fetch unit is the slave; its environment is the master.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_req;
  logic                  fetch_ack;
  logic                  flush;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  instr_valid;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic [DATA_WIDTH-1:0] instr_data;
  logic                  instr_ready;

  modport slave (
    input  fetch_addr, fetch_req, flush, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    output fetch_ack, mem_req, mem_addr, instr_valid, instr_addr, instr_data
  );

  modport master (
    output fetch_addr, fetch_req, flush, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    input  fetch_ack, mem_req, mem_addr, instr_valid, instr_addr, instr_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues in-order memory reads for PC addresses,
// buffers returned words in a slot FIFO and presents {addr, data} to decode.
// A flush drops buffered entries and counts in-flight responses to discard.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  instr_fetch_unit_if.slave bus
);
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] ONE     = PW'(1);

  logic [PW-1:0]         alloc_ptr, fill_ptr, rd_ptr, drop_cnt;
  logic [ADDR_WIDTH-1:0] slot_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] slot_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] slot_filled;

  logic [IW-1:0] alloc_idx, fill_idx, rd_idx;
  logic [PW-1:0] used, in_flight, flush_sum, flush_drop;
  logic          fill_ok, head_valid, pop;

  // Credit accounting, request issue and head-of-queue presentation.
  always_comb begin
    alloc_idx  = alloc_ptr[IW-1:0];
    fill_idx   = fill_ptr[IW-1:0];
    rd_idx     = rd_ptr[IW-1:0];
    // used never exceeds FIFO_DEPTH, so PW bits hold it without overflow
    used       = (alloc_ptr - rd_ptr) + drop_cnt;
    in_flight  = alloc_ptr - fill_ptr;

    bus.mem_req   = bus.fetch_req & ~bus.flush & ~reset & (used < DEPTH_C);
    bus.mem_addr  = bus.fetch_addr;
    bus.fetch_ack = bus.mem_req & bus.mem_gnt;

    fill_ok    = bus.mem_rvalid & (drop_cnt == '0) & (fill_ptr != alloc_ptr);
    head_valid = slot_filled[rd_idx] & (rd_ptr != fill_ptr);
    pop        = head_valid & bus.instr_ready;

    bus.instr_valid = head_valid;
    bus.instr_addr  = slot_addr[rd_idx];
    bus.instr_data  = slot_data[rd_idx];

    // an rvalid arriving in the flush cycle consumes one of the drops itself
    flush_sum  = drop_cnt + in_flight;
    flush_drop = (bus.mem_rvalid && flush_sum != '0) ? flush_sum - ONE : flush_sum;
  end

  // Pointer, drop counter and slot updates; flush overrides allocate/fill/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      drop_cnt    <= '0;
      slot_filled <= '0;
      slot_addr   <= '{default: '0};
      slot_data   <= '{default: '0};
    end else if (bus.flush) begin
      alloc_ptr   <= rd_ptr;
      fill_ptr    <= rd_ptr;
      slot_filled <= '0;
      drop_cnt    <= flush_drop;
    end else begin
      if (bus.fetch_ack) begin
        slot_addr[alloc_idx]   <= bus.fetch_addr;
        slot_filled[alloc_idx] <= 1'b0;
        alloc_ptr              <= alloc_ptr + ONE;
      end
      if (bus.mem_rvalid && drop_cnt != '0) begin
        drop_cnt <= drop_cnt - ONE;
      end else if (fill_ok) begin
        slot_data[fill_idx]   <= bus.mem_rdata;
        slot_filled[fill_idx] <= 1'b1;
        fill_ptr              <= fill_ptr + ONE;
      end
      if (pop) begin
        slot_filled[rd_idx] <= 1'b0;
        rd_ptr              <= rd_ptr + ONE;
      end
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Fetch stage directly downstream of the program counter: it consumes the PC's `current_address`, issues in-order instruction-memory reads, and buffers the returned words.
- Hands `{address, instruction}` pairs to decode over a valid/ready handshake, so the PC advances only when fetch accepts its address.
- Supports pipelined memory with up to FIFO_DEPTH requests outstanding.
- A `flush` input discards all buffered and in-flight fetches on a redirect.

## Interface
- ADDR_WIDTH, 32, width of fetch and memory addresses
- DATA_WIDTH, 32, instruction word width
- FIFO_DEPTH, 4, slot count (power of 2, ≥2); also the limit on outstanding requests
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  one clock; reset is asynchronous and active-high
- fetch_addr  in  ADDR_WIDTH  address from PC `current_address`
- fetch_req  in  1  PC presents a valid address
- fetch_ack  out  1  address accepted this cycle; PC may load its next address
- flush  in  1  redirect: drop all buffered and in-flight fetches
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_WIDTH  memory read address
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid; responses return in grant order, ≥1 cycle after grant
- mem_rdata  in  DATA_WIDTH  read data
- instr_valid  out  1  head slot holds a returned instruction
- instr_addr  out  ADDR_WIDTH  address of head instruction
- instr_data  out  DATA_WIDTH  head instruction word
- instr_ready  in  1  decode consumes head when high with instr_valid

## Operation
- **Slot FIFO**
  - Three pointers, each log2(FIFO_DEPTH)+1 bits with wrap bit: alloc_ptr, fill_ptr, rd_ptr.
  - Each slot holds addr, data and a filled flag.
- **Request path**
  - Credits rule: used = (alloc_ptr − rd_ptr) + drop_cnt. A request may issue only while used < FIFO_DEPTH.
  - `mem_req` = fetch_req & !flush & (used < FIFO_DEPTH), combinational.
  - `mem_addr` = fetch_addr.
  - `fetch_ack` = mem_req & mem_gnt.
- **Allocate**
  - On fetch_ack, write fetch_addr into slot[alloc_ptr], clear its filled flag, and increment alloc_ptr.
- **Response path**
  - On mem_rvalid with drop_cnt > 0: discard the data and decrement drop_cnt.
  - Otherwise, write mem_rdata into slot[fill_ptr], set filled, and increment fill_ptr.
  - mem_rvalid with no unfilled slot and drop_cnt = 0 is a protocol error; the data is ignored and no state changes.
- **Output path**
  - `instr_valid` = slot[rd_ptr].filled & (rd_ptr ≠ fill_ptr).
  - `instr_addr` and `instr_data` come from slot[rd_ptr].
  - On instr_valid & instr_ready, clear the head slot's filled flag and increment rd_ptr.
- **Flush**
  - Takes priority over pop, fill and allocate in the same cycle.
  - Sets alloc_ptr = fill_ptr = rd_ptr and clears all filled flags.
  - Sets drop_cnt = drop_cnt + (alloc_ptr − fill_ptr) − (mem_rvalid ? 1 : 0), saturating at 0. This counts every granted, unreturned request; an rvalid in the flush cycle is itself dropped.
  - mem_req and fetch_ack are 0 in the flush cycle.
- **Simultaneous events**
  - Allocate, fill and pop in one cycle are all legal and independent.
  - A full FIFO (used = FIFO_DEPTH) with a same-cycle pop does not admit a new request that cycle, because credits use registered state.
- **Alignment**
  - The block performs no alignment check; low address bits are passed through unchanged.

## Timing
- **Reset (async assert)**
  - All pointers and drop_cnt are 0 and all filled flags are clear.
  - instr_valid=0, instr_addr=0, instr_data=0.
  - fetch_ack and mem_req are 0 while reset is high.
- **Latency**
  - Request grant in cycle N.
  - Earliest mem_rvalid is cycle N+1.
  - instr_valid is high from cycle N+2 (data registered; no bypass).
- **Throughput**
  - One grant per cycle sustained when the memory has 1-cycle latency and decode is always ready.
- **Combinational paths**
  - mem_req and fetch_ack are combinational from fetch_req, flush and mem_gnt; instr_* are registered.
- **Reset mid-operation**
  - All state is lost immediately.
  - The environment must not return responses for pre-reset grants.

## Test plan
- **Reset**: assert reset during traffic → instr_valid=0 and mem_req=0 in the same cycle; all pointers read 0 after release.
- **Streaming**: 1-cycle memory, instr_ready=1, fetch_addr 0x1000_0000, 0x1000_0004, 0x1000_0008… (rdata = addr ^ 0xFFFF_FFFF) → one fetch_ack per cycle; matching pairs appear in order, first one 2 cycles after the first grant.
- **Backpressure**: instr_ready=0, fetch_req=1 held, immediate grant → exactly 4 fetch_acks, then mem_req=0; raising instr_ready drains 4 entries in order and the next request is granted one cycle after the first pop.
- **Flush with in-flight**: 3 grants to 0x200/0x204/0x208 with memory stalled, then flush; new address 0x400 granted; memory returns 4 responses → the first 3 are discarded and only {0x400, data} reaches decode.
- **Flush/rvalid collision**: flush and mem_rvalid in the same cycle with 2 outstanding → drop_cnt=1; the next rvalid is dropped and the one after it is delivered.
- **Grant stall**: mem_gnt=0 for 5 cycles with fetch_req=1 → fetch_ack=0 throughout, mem_addr stable, no slot allocated.
